// File: rtl/crc_code_pkg.sv
// Shared CRC constants and FSM state type used by both ends of the
// CRC-protected memory path (encoder and decoder).
package crc_code_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefCrcWidth  = 8;
  localparam logic [7:0]  DefPoly      = 8'h07;
  localparam logic [7:0]  DefInit      = 8'h00;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/crc_code_decoder_if.sv
// Read-path bundle between the memory read port and the CRC checker.
interface crc_code_decoder_if import crc_code_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned CRC_WIDTH  = DefCrcWidth
);
    logic                            start;
    logic [DATA_WIDTH+CRC_WIDTH-1:0] codeword_in;
    logic [DATA_WIDTH-1:0]           data_out;
    logic                            crc_error;
    logic                            data_valid;
    logic                            busy;

    modport master (
        output start, codeword_in,
        input  data_out, crc_error, data_valid, busy
    );

    modport slave (
        input  start, codeword_in,
        output data_out, crc_error, data_valid, busy
    );
endinterface

// File: rtl/crc_lfsr_serial.sv
// One-bit-per-cycle CRC LFSR step, shared by the CRC encoder and decoder.
module crc_lfsr_serial import crc_code_pkg::*; #(
    parameter int unsigned          CRC_WIDTH = DefCrcWidth,
    parameter logic [CRC_WIDTH-1:0] POLY      = DefPoly,
    parameter logic [CRC_WIDTH-1:0] INIT      = DefInit
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 bit_i,
    input  logic                 shift_en_i,
    input  logic                 load_en_i,
    input  logic [CRC_WIDTH-1:0] init_i,
    output logic [CRC_WIDTH-1:0] lfsr_o,
    output logic [CRC_WIDTH-1:0] lfsr_next_o
);
    logic [CRC_WIDTH-1:0] lfsr_q;
    logic [CRC_WIDTH-1:0] lfsr_d;
    logic                 fb;

    always_comb begin
        fb     = lfsr_q[CRC_WIDTH-1] ^ bit_i;
        lfsr_d = {lfsr_q[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= INIT;
        end else if (load_en_i) begin
            lfsr_q <= init_i;
        end else if (shift_en_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o      = lfsr_q;
    assign lfsr_next_o = lfsr_d;
endmodule

// File: rtl/crc_code_decoder.sv
// Self-sequenced bit-serial CRC checker: one start pulse runs the whole codeword
// through the LFSR and reports the data with a pass/fail flag.
module crc_code_decoder import crc_code_pkg::*; #(
    parameter int unsigned          DATA_WIDTH = DefDataWidth,
    parameter int unsigned          CRC_WIDTH  = DefCrcWidth,
    parameter logic [CRC_WIDTH-1:0] POLY       = DefPoly,
    parameter logic [CRC_WIDTH-1:0] INIT       = DefInit
) (
    input  logic               clk,
    input  logic               rst,
    crc_code_decoder_if.slave  bus
);
    localparam int unsigned N    = DATA_WIDTH + CRC_WIDTH;
    localparam int unsigned CntW = $clog2(N + 1);

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [N-1:0]          sreg_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;
    logic                  valid_q;
    logic                  busy_q;

    logic                  load_en;
    logic                  shift_en;
    logic [N-1:0]          sreg_rot;
    logic [CRC_WIDTH-1:0]  lfsr_q;
    logic [CRC_WIDTH-1:0]  lfsr_d;

    assign load_en  = (state_q == StIdle) && bus.start;
    assign shift_en = (state_q == StShift);
    // Rotating instead of shifting returns the codeword to its original
    // alignment after N steps, so the data needs no separate holding copy.
    assign sreg_rot = {sreg_q[N-2:0], sreg_q[N-1]};

    crc_lfsr_serial #(
        .CRC_WIDTH (CRC_WIDTH),
        .POLY      (POLY),
        .INIT      (INIT)
    ) u_lfsr (
        .clk_i       (clk),
        .rst_i       (rst),
        .bit_i       (sreg_q[N-1]),
        .shift_en_i  (shift_en),
        .load_en_i   (load_en),
        .init_i      (INIT),
        .lfsr_o      (lfsr_q),
        .lfsr_next_o (lfsr_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sreg_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        sreg_q  <= bus.codeword_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    sreg_q <= sreg_rot;
                    cnt_q  <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(N - 1)) begin
                        data_q  <= sreg_rot[N-1 -: DATA_WIDTH];
                        err_q   <= |lfsr_d;
                        valid_q <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // While the result is presented the LFSR still holds the final syndrome.
    assert property (@(posedge clk) disable iff (rst)
                     valid_q |-> (err_q == (lfsr_q != '0)));

    assign bus.data_out   = data_q;
    assign bus.crc_error  = err_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_crc_code_decoder.sv
// Directed bench for crc_code_decoder: scoreboard of expected results checked on
// each data_valid pulse, plus latency, busy, ignore-start, back-to-back and reset checks.
module tb_crc_code_decoder;
    import crc_code_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
    localparam int unsigned N  = DW + CW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    crc_code_decoder_if bus_if ();

    crc_code_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   n_valid = 0;
    int   n_exp   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Polynomial long division by x^8+x^2+x+1, independent of any LFSR form.
    function automatic logic [CW-1:0] model_rem(input logic [N-1:0] cw);
        logic [N-1:0] r;
        logic [N-1:0] g;
        r = cw;
        g = {{(N-CW-1){1'b0}}, 1'b1, DefPoly};
        for (int i = N - 1; i >= CW; i--) begin
            if (r[i]) r = r ^ (g << (i - CW));
        end
        return r[CW-1:0];
    endfunction

    function automatic logic [N-1:0] make_cw(input logic [DW-1:0] d);
        return {d, model_rem({d, {CW{1'b0}}})};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [N-1:0] cw);
        exp_t e;
        e.data = cw[N-1:CW];
        e.err  = (model_rem(cw) != '0);
        sb.push_back(e);
        n_exp++;
    endtask

    // Accept one codeword and verify latency and busy width.
    task automatic run_check(input logic [N-1:0] cw);
        int lat;
        int busy_n;
        bus_if.codeword_in = cw;
        bus_if.start       = 1'b1;
        push_exp(cw);
        step();
        check("busy_after_accept", 64'(bus_if.busy), 64'd1);
        bus_if.start = 1'b0;
        lat    = 0;
        busy_n = 1;
        while (lat < 100) begin
            step();
            lat++;
            if (bus_if.busy) busy_n++;
            if (bus_if.data_valid) break;
        end
        check("latency", 64'(lat), 64'(N));
        step();
        check("busy_after_done", 64'(bus_if.busy), 64'd0);
        check("busy_cycles", 64'(busy_n), 64'(N + 1));
    endtask

    always @(negedge clk) begin
        if (!rst && bus_if.data_valid) begin
            exp_t e;
            n_valid++;
            check("sb_occupied", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("data_out", 64'(bus_if.data_out), 64'(e.data));
                check("crc_error", 64'(bus_if.crc_error), 64'(e.err));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] cw;
        int           v0;
        int           rises;
        int           t;
        int           rt[3];
        logic         prev;

        bus_if.start       = 1'b0;
        bus_if.codeword_in = '0;
        rst                = 1'b1;
        step();
        step();
        check("rst_busy", 64'(bus_if.busy), 64'd0);
        check("rst_valid", 64'(bus_if.data_valid), 64'd0);
        check("rst_err", 64'(bus_if.crc_error), 64'd0);
        check("rst_data", 64'(bus_if.data_out), 64'd0);
        rst = 1'b0;
        step();

        // Directed codewords
        run_check({32'h0000_0000, 8'h00});
        run_check({32'h0000_0001, 8'h07});
        run_check({32'h0000_0003, 8'h07});
        run_check({32'h0000_0080, 8'h89});
        run_check({32'h0000_0080, 8'h88});

        // Random data, alternately clean and with one flipped bit
        for (int i = 0; i < 4; i++) begin
            cw = make_cw($urandom);
            if (i[0]) cw = cw ^ (40'd1 << $urandom_range(N - 1, 0));
            run_check(cw);
        end

        // start pulses during SHIFT/DONE and codeword changes after accept are ignored
        v0 = n_valid;
        cw = {32'h0000_0001, 8'h07};
        bus_if.codeword_in = cw;
        bus_if.start       = 1'b1;
        push_exp(cw);
        step();
        for (int k = 1; k <= 45; k++) begin
            if (k == 2) bus_if.codeword_in = 40'hFF_FFFF_FFFF;
            bus_if.start = (k == 5) || (k == 20) || (k == 41);
            step();
        end
        check("ignore_one_valid", 64'(n_valid - v0), 64'd1);
        check("ignore_idle", 64'(bus_if.busy), 64'd0);

        // start held high: back-to-back accepts at N+2 spacing
        v0    = n_valid;
        cw    = {32'h0000_0080, 8'h89};
        bus_if.codeword_in = cw;
        bus_if.start       = 1'b1;
        for (int i = 0; i < 3; i++) push_exp(cw);
        rises = 0;
        t     = 0;
        prev  = bus_if.busy;
        while (rises < 3 && t < 300) begin
            step();
            t++;
            if (bus_if.busy && !prev) begin
                rt[rises] = t;
                rises++;
            end
            prev = bus_if.busy;
        end
        bus_if.start = 1'b0;
        check("held_accepts", 64'(rises), 64'd3);
        if (rises == 3) begin
            check("held_gap1", 64'(rt[1] - rt[0]), 64'(N + 2));
            check("held_gap2", 64'(rt[2] - rt[1]), 64'(N + 2));
        end
        repeat (N + 5) step();
        check("held_valids", 64'(n_valid - v0), 64'd3);
        check("held_idle", 64'(bus_if.busy), 64'd0);

        // Reset mid-check abandons it
        v0 = n_valid;
        bus_if.codeword_in = {32'h0000_0003, 8'h07};
        bus_if.start       = 1'b1;
        step();
        bus_if.start = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(bus_if.busy), 64'd0);
        check("midrst_valid", 64'(bus_if.data_valid), 64'd0);
        check("midrst_data", 64'(bus_if.data_out), 64'd0);
        check("midrst_err", 64'(bus_if.crc_error), 64'd0);
        step();
        step();
        rst = 1'b0;
        repeat (50) step();
        check("midrst_no_valid", 64'(n_valid - v0), 64'd0);
        run_check({32'h0000_0080, 8'h89});

        repeat (3) step();
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("valid_total", 64'(n_valid), 64'(n_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
